// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, opcode map and idle ALU code.
// Build option CTRL_ILLEGAL_TRAP_EN (used by multicycle_control) traps reserved opcodes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } ctrl_state_e;

  localparam logic [3:0] OP_ADDI_R = 4'b0000;
  localparam logic [3:0] OP_SLL    = 4'b0001;
  localparam logic [3:0] OP_SLR    = 4'b0010;
  localparam logic [3:0] OP_MOV    = 4'b0011;
  localparam logic [3:0] OP_OR     = 4'b0100;
  localparam logic [3:0] OP_XOR    = 4'b0101;
  localparam logic [3:0] OP_ADD    = 4'b0110;
  localparam logic [3:0] OP_ADDI   = 4'b0111;
  localparam logic [3:0] OP_BNE    = 4'b1000;
  localparam logic [3:0] OP_BEQ    = 4'b1001;
  localparam logic [3:0] OP_MOVI   = 4'b1010;
  localparam logic [3:0] OP_SW     = 4'b1011;
  localparam logic [3:0] OP_LW     = 4'b1100;
  localparam logic [3:0] OP_HALT   = 4'b1110;
  localparam logic [3:0] OP_NOP    = 4'b1111;

  localparam logic [3:0] ALUOP_NOP = 4'b1111;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles spent without mem_ready; expired flags the cycle whose increment hits LIMIT.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (clear) begin
      r_count <= 8'd0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Widened compare so LIMIT=255 cannot wrap.
  assign expired = enable && (({1'b0, r_count} + 9'd1) == 9'(LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory handshake timeout and halt.
// Define CTRL_ILLEGAL_TRAP_EN to trap reserved opcodes (err + HALT) instead of running them as NOP.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW         = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] instr,
  input  logic           equal,
  input  logic           mem_ready,
  output logic           pc_en,
  output logic           ir_write,
  output logic           RegDst,
  output logic           Branch,
  output logic           MemtoReg,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           ALUsrc,
  output logic           RegWrite,
  output logic [OPW-1:0] ALUOp,
  output logic           busy,
  output logic           err
);

  localparam logic [OPW-1:0] AluOpIdle = {OPW{ALUOP_NOP[0]}};

  ctrl_state_e    r_state, w_state_next;
  logic [OPW-1:0] r_op;
  logic           r_err;
  logic           w_trap, w_expired;

  function automatic logic is_op(input logic [OPW-1:0] op, input logic [3:0] code);
    return op == OPW'(code);
  endfunction

  // Decode of the incoming opcode, used only for the DECODE branch.
  logic w_in_nop, w_in_halt, w_in_rsvd;
  assign w_in_nop  = is_op(instr, OP_NOP);
  assign w_in_halt = is_op(instr, OP_HALT);
  assign w_in_rsvd = !(is_op(instr, OP_ADDI_R) || is_op(instr, OP_SLL) || is_op(instr, OP_SLR) ||
                       is_op(instr, OP_MOV) || is_op(instr, OP_OR) || is_op(instr, OP_XOR) ||
                       is_op(instr, OP_ADD) || is_op(instr, OP_ADDI) || is_op(instr, OP_BNE) ||
                       is_op(instr, OP_BEQ) || is_op(instr, OP_MOVI) || is_op(instr, OP_SW) ||
                       is_op(instr, OP_LW) || w_in_halt || w_in_nop);

  // Decode of the latched opcode, drives all datapath strobes.
  logic w_lw, w_sw, w_beq, w_bne, w_reg_dst, w_alu_src;
  assign w_lw      = is_op(r_op, OP_LW);
  assign w_sw      = is_op(r_op, OP_SW);
  assign w_beq     = is_op(r_op, OP_BEQ);
  assign w_bne     = is_op(r_op, OP_BNE);
  assign w_reg_dst = is_op(r_op, OP_ADDI_R) || is_op(r_op, OP_SLL) || is_op(r_op, OP_SLR) ||
                     is_op(r_op, OP_MOV) || is_op(r_op, OP_OR) || is_op(r_op, OP_XOR) ||
                     is_op(r_op, OP_ADD) || w_lw;
  assign w_alu_src = is_op(r_op, OP_ADDI_R) || is_op(r_op, OP_SLL) || is_op(r_op, OP_SLR) ||
                     is_op(r_op, OP_ADDI) || is_op(r_op, OP_MOVI) || w_sw || w_lw;

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (r_state != StMem),
    .enable  ((r_state == StMem) && !mem_ready),
    .expired (w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    w_trap       = 1'b0;
    unique case (r_state)
      StIdle:   if (start) w_state_next = StFetch;
      StFetch:  w_state_next = StDecode;
      StDecode: begin
        if (w_in_nop) begin
          w_state_next = StFetch;
        end else if (w_in_halt) begin
          w_state_next = StHalt;
        end else if (w_in_rsvd) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_state_next = StHalt;
          w_trap       = 1'b1;
`else
          w_state_next = StFetch;
`endif
        end else begin
          w_state_next = StExec;
        end
      end
      StExec: begin
        if (w_lw || w_sw)        w_state_next = StMem;
        else if (w_beq || w_bne) w_state_next = StFetch;
        else                     w_state_next = StWb;
      end
      // mem_ready wins over a simultaneous timeout.
      StMem: begin
        if (mem_ready)      w_state_next = w_lw ? StWb : StFetch;
        else if (w_expired) w_state_next = StHalt;
      end
      StWb:    w_state_next = StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op    <= AluOpIdle;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StDecode) r_op <= instr;
      if (w_trap || w_expired) r_err <= 1'b1;
    end
  end

  always_comb begin
    pc_en    = 1'b0;
    ir_write = 1'b0;
    RegDst   = 1'b0;
    Branch   = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUsrc   = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = AluOpIdle;
    busy     = (r_state != StIdle) && (r_state != StHalt);
    err      = r_err;
    case (r_state)
      StFetch: begin
        pc_en    = 1'b1;
        ir_write = 1'b1;
      end
      StExec: begin
        ALUOp  = r_op;
        RegDst = w_reg_dst;
        ALUsrc = w_alu_src;
        Branch = (w_beq && equal) || (w_bne && !equal);
      end
      StMem: begin
        ALUOp    = r_op;
        MemRead  = w_lw;
        MemWrite = w_sw;
      end
      StWb: begin
        ALUOp    = r_op;
        RegDst   = w_reg_dst;
        ALUsrc   = w_alu_src;
        MemtoReg = w_lw;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle check against an instruction-level phase model.
// Honours CTRL_ILLEGAL_TRAP_EN for the reserved-opcode case.
module tb_multicycle_control;

  localparam int unsigned MemTimeout = 15;
  localparam int PI = 0, PF = 1, PD = 2, PE = 3, PM = 4, PW = 5, PH = 6;

  logic       clk, rst_n, start, equal, mem_ready;
  logic [3:0] instr;
  logic       pc_en, ir_write, RegDst, Branch, MemtoReg, MemRead, MemWrite, ALUsrc, RegWrite;
  logic [3:0] ALUOp;
  logic       busy, err;

  multicycle_control #(
    .OPW         (4),
    .MEM_TIMEOUT (MemTimeout)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .equal     (equal),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .ir_write  (ir_write),
    .RegDst    (RegDst),
    .Branch    (Branch),
    .MemtoReg  (MemtoReg),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUsrc    (ALUsrc),
    .RegWrite  (RegWrite),
    .ALUOp     (ALUOp),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: {pc_en, ir_write, RegDst, Branch, MemtoReg, MemRead, MemWrite, ALUsrc, RegWrite,
  //               ALUOp[3:0], busy, err}
  logic [14:0] dut_vec;
  assign dut_vec = {pc_en, ir_write, RegDst, Branch, MemtoReg, MemRead, MemWrite, ALUsrc,
                    RegWrite, ALUOp, busy, err};

  logic [14:0] exp_vec, lit_vec, wb_lit;
  logic        chk_en, lit_en, wb_lit_en, m_err;
  string       cur_tag, lit_tag;
  int          n_chk = 0;
  int          n_pass = 0;

  // Expected outputs for one phase of an instruction, straight from the opcode rules.
  function automatic logic [14:0] exp_out(input int ph, input logic [3:0] op, input logic eq,
                                          input logic er);
    int         o     = int'(op);
    logic       in_ew = (ph == PE) || (ph == PW);
    logic       rd    = in_ew && (o <= 6 || o == 12);
    logic       src   = in_ew && (o <= 2 || o == 7 || o == 10 || o == 11 || o == 12);
    logic       br    = (ph == PE) && ((o == 9 && eq) || (o == 8 && !eq));
    logic       mtr   = (ph == PW) && (o == 12);
    logic       mr    = (ph == PM) && (o == 12);
    logic       mw    = (ph == PM) && (o == 11);
    logic       rw    = (ph == PW);
    logic [3:0] alu   = (ph >= PE && ph <= PW) ? op : 4'hF;
    logic       bsy   = (ph != PI) && (ph != PH);
    logic       f     = (ph == PF);
    return {f, f, rd, br, mtr, mr, mw, src, rw, alu, bsy, er};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk = n_chk + 1;
      if (dut_vec === exp_vec) n_pass = n_pass + 1;
      else $display("FAIL %s: got %b want %b", cur_tag, dut_vec, exp_vec);
      if (lit_en) begin
        n_chk = n_chk + 1;
        if (dut_vec === lit_vec) n_pass = n_pass + 1;
        else $display("FAIL %s: got %b want %b", lit_tag, dut_vec, lit_vec);
      end
    end
  end

  task automatic step(input logic [14:0] e, input string tag);
    exp_vec = e;
    cur_tag = tag;
    chk_en  = 1'b1;
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic lit(input string name, input logic [14:0] v);
    lit_tag = name;
    lit_vec = v;
    lit_en  = 1'b1;
  endtask

  // One instruction from FETCH; w = MEM cycles before mem_ready, never = hold mem_ready low.
  task automatic run(input logic [3:0] op, input logic eq, input int w, input bit never,
                     input string tag);
    instr     = op;
    equal     = !eq;
    mem_ready = 1'b0;
    step(exp_out(PF, op, eq, m_err), {tag, "/fetch"});
    step(exp_out(PD, op, eq, m_err), {tag, "/decode"});
    instr = ~op;
    if (op == 4'hF || op == 4'hE) return;
    if (op == 4'hD) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      m_err = 1'b1;
`endif
      return;
    end
    equal = eq;
    step(exp_out(PE, op, eq, m_err), {tag, "/exec"});
    equal = !eq;
    if (op == 4'h8 || op == 4'h9) return;
    if (op == 4'hB || op == 4'hC) begin
      if (never) begin
        for (int i = 0; i < int'(MemTimeout); i++) step(exp_out(PM, op, eq, m_err), {tag, "/mem"});
        m_err = 1'b1;
        return;
      end
      for (int i = 0; i < w; i++) step(exp_out(PM, op, eq, m_err), {tag, "/mem_wait"});
      mem_ready = 1'b1;
      step(exp_out(PM, op, eq, m_err), {tag, "/mem_done"});
      mem_ready = 1'b0;
      if (op == 4'hB) return;
    end
    if (wb_lit_en) lit({tag, "/wb_literal"}, wb_lit);
    step(exp_out(PW, op, eq, m_err), {tag, "/wb"});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr = 4'hF; equal = 1'b0; mem_ready = 1'b0;
    m_err = 1'b0; chk_en = 1'b0; lit_en = 1'b0; wb_lit_en = 1'b0; wb_lit = '0;
    exp_vec = '0; lit_vec = '0;
    @(posedge clk);
    #1;
    lit("reset_values", 15'b000000000_1111_00);
    step(exp_out(PI, 4'h0, 1'b0, 1'b0), "reset_idle");
    rst_n = 1'b1;
    step(exp_out(PI, 4'h0, 1'b0, 1'b0), "idle_no_start");
    start = 1'b1;
    step(exp_out(PI, 4'h0, 1'b0, 1'b0), "idle_start");

    // start stays high through the first instructions: ignored outside IDLE.
    lit("fetch_strobes", 15'b110000000_1111_10);
    wb_lit = 15'b001000001_0110_10; wb_lit_en = 1'b1;
    run(4'h6, 1'b0, 0, 1'b0, "add");
    wb_lit_en = 1'b0;
    run(4'h9, 1'b1, 0, 1'b0, "beq_eq1");
    start = 1'b0;
    run(4'h9, 1'b0, 0, 1'b0, "beq_eq0");
    run(4'h8, 1'b0, 0, 1'b0, "bne_eq0");
    run(4'h8, 1'b1, 0, 1'b0, "bne_eq1");
    run(4'h0, 1'b0, 0, 1'b0, "addi_r");
    run(4'h1, 1'b0, 0, 1'b0, "sll");
    run(4'h2, 1'b0, 0, 1'b0, "slr");
    run(4'h3, 1'b0, 0, 1'b0, "mov");
    run(4'h4, 1'b0, 0, 1'b0, "or");
    run(4'h5, 1'b1, 0, 1'b0, "xor");
    run(4'h7, 1'b0, 0, 1'b0, "addi");
    run(4'hA, 1'b0, 0, 1'b0, "movi");
    wb_lit = 15'b001010011_1100_10; wb_lit_en = 1'b1;
    run(4'hC, 1'b0, 3, 1'b0, "lw_w3");
    wb_lit_en = 1'b0;
    run(4'hC, 1'b0, 0, 1'b0, "lw_w0");
    run(4'hB, 1'b0, 2, 1'b0, "sw_w2");
    run(4'hB, 1'b0, 0, 1'b0, "sw_w0");
    run(4'hF, 1'b0, 0, 1'b0, "nop");

    run(4'hB, 1'b0, 0, 1'b1, "sw_timeout");
    start = 1'b1;
    lit("halt_after_timeout", 15'b000000000_1111_01);
    step(exp_out(PH, 4'hB, 1'b0, m_err), "halt1");
    step(exp_out(PH, 4'hB, 1'b0, m_err), "halt2");
    start = 1'b0;
    rst_n = 1'b0;
    step(exp_out(PH, 4'hB, 1'b0, m_err), "halt_reset_edge");
    m_err = 1'b0;
    step(exp_out(PI, 4'h0, 1'b0, m_err), "idle_after_halt");
    rst_n = 1'b1; start = 1'b1;
    step(exp_out(PI, 4'h0, 1'b0, m_err), "restart1");
    start = 1'b0;

    // Reset while LW waits in MEM.
    instr = 4'hC; mem_ready = 1'b0;
    step(exp_out(PF, 4'hC, 1'b0, m_err), "midmem/fetch");
    step(exp_out(PD, 4'hC, 1'b0, m_err), "midmem/decode");
    instr = 4'h3;
    step(exp_out(PE, 4'hC, equal, m_err), "midmem/exec");
    step(exp_out(PM, 4'hC, 1'b0, m_err), "midmem/mem1");
    rst_n = 1'b0;
    step(exp_out(PM, 4'hC, 1'b0, m_err), "midmem/mem2");
    lit("reset_mid_mem", 15'b000000000_1111_00);
    step(exp_out(PI, 4'h0, 1'b0, m_err), "midmem/idle");
    rst_n = 1'b1; start = 1'b1;
    step(exp_out(PI, 4'h0, 1'b0, m_err), "restart2");
    start = 1'b0;
    run(4'h6, 1'b0, 0, 1'b0, "add_after_reset");

    run(4'hD, 1'b0, 0, 1'b0, "reserved");
`ifdef CTRL_ILLEGAL_TRAP_EN
    lit("reserved_trap", 15'b000000000_1111_01);
    step(exp_out(PH, 4'hD, 1'b0, m_err), "reserved/halt");
    step(exp_out(PH, 4'hD, 1'b0, m_err), "reserved/halt2");
`else
    lit("reserved_as_nop", 15'b110000000_1111_10);
    run(4'h5, 1'b0, 0, 1'b0, "xor_after_reserved");
`endif

    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
